// File: rtl/clock_ctrl.sv
// -----------------------------------------------------------------------------
// clock_ctrl
//   Sequencing controller for the digital clock datapath. A prescaler turns
//   the 50 MHz system clock into a one-cycle tick enable. That tick drives the
//   cascaded sec/min/hour counters. A RUN/SET mode FSM lets single-cycle button
//   pulses edit the fields. Every output is a flop.
//
// Ports
//   clk      in   system clock (50 MHz)
//   rst_n    in   asynchronous active-low reset
//   num      in   [31:0] clk cycles per one-second tick (0 and 1 both mean every cycle)
//   i_mode   in   pulse: toggle RUN/SET (takes priority over i_pos/i_inc)
//   i_pos    in   pulse: advance the selected field in SET (sec->min->hour->sec)
//   i_inc    in   pulse: increment the selected field in SET (wraps, no carry)
//   o_sec    out  [5:0] seconds
//   o_min    out  [5:0] minutes
//   o_hour   out  [4:0] hours
//   o_mode   out  0=RUN, 1=SET
//   o_sel    out  [1:0] selected field, 0=sec 1=min 2=hour
//   o_tick   out  one-cycle pulse on each one-second tick
//   o_blank  out  display blink phase in SET (present only with CLK_BLINK_EN)
//
// Build option
//   CLK_BLINK_EN : when defined, adds o_blank and the blink counter.
// -----------------------------------------------------------------------------
module clock_ctrl #(
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] num,
    input  logic        i_mode,
    input  logic        i_pos,
    input  logic        i_inc,
    output logic [5:0]  o_sec,
    output logic [5:0]  o_min,
    output logic [4:0]  o_hour,
    output logic        o_mode,
    output logic [1:0]  o_sel,
    output logic        o_tick
`ifdef CLK_BLINK_EN
    ,
    output logic        o_blank
`endif
);

    localparam logic [5:0] SEC_LIM  = 6'(SEC_MAX);
    localparam logic [5:0] MIN_LIM  = 6'(MIN_MAX);
    localparam logic [4:0] HOUR_LIM = 5'(HOUR_MAX);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Control strobes decoded from the FSM.
    logic run_en;     // prescaler is counting this cycle
    logic enter_set;  // RUN -> SET transition on this edge
    logic set_pos;    // field-select advance accepted
    logic set_inc;    // field increment accepted
`ifdef CLK_BLINK_EN
    logic blink_en;   // blink counter is running this cycle
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (i_mode) state_nxt = (state == RUN) ? SET : RUN;
    end

    // ------------------------------------------------------------------
    // FSM: control outputs. i_mode masks i_pos/i_inc in the same cycle.
    // The cycle that leaves RUN does not count, so the prescaler is
    // cleared on SET entry. The cycle that leaves SET also does not
    // count, so the prescaler restarts from 0 on the return edge.
    // ------------------------------------------------------------------
    always_comb begin
        run_en    = 1'b0;
        enter_set = 1'b0;
        set_pos   = 1'b0;
        set_inc   = 1'b0;
`ifdef CLK_BLINK_EN
        blink_en  = 1'b0;
`endif
        case (state)
            RUN: begin
                run_en    = !i_mode;
                enter_set = i_mode;
            end
            SET: begin
                set_pos   = !i_mode && i_pos;
                set_inc   = !i_mode && i_inc;
`ifdef CLK_BLINK_EN
                blink_en  = !i_mode;
`endif
            end
            default: ;
        endcase
    end

    assign o_mode = (state == SET);

    // ------------------------------------------------------------------
    // Prescaler. The compare is cnt+1 >= num, done one bit wider.
    // This covers num=0 (always true) and avoids the num-1 underflow.
    // A num that drops below cnt takes effect on the very next edge.
    // ------------------------------------------------------------------
    logic [31:0] cnt;
    logic        tick_hit;
    logic        tick_now;

    assign tick_hit = ({1'b0, cnt} + 33'd1) >= {1'b0, num};
    assign tick_now = run_en && tick_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else if (run_en) begin
            if (tick_hit) begin
                cnt    <= '0;
                o_tick <= 1'b1;
            end else begin
                cnt    <= cnt + 32'd1;
                o_tick <= 1'b0;
            end
        end else begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Field select
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sel <= 2'd0;
        end else if (enter_set) begin
            o_sel <= 2'd0;
        end else if (set_pos) begin
            o_sel <= (o_sel >= 2'd2) ? 2'd0 : o_sel + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Time fields. Wrap tests use >= so that an out-of-range value can
    // never persist. The fields update on the same edge that raises
    // o_tick. An edit in SET reads o_sel before any same-cycle i_pos
    // advance, so i_inc hits the old field.
    // ------------------------------------------------------------------
    logic sec_wrap, min_wrap, hour_wrap;

    assign sec_wrap  = (o_sec  >= SEC_LIM);
    assign min_wrap  = (o_min  >= MIN_LIM);
    assign hour_wrap = (o_hour >= HOUR_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sec  <= '0;
            o_min  <= '0;
            o_hour <= '0;
        end else if (tick_now) begin
            if (!sec_wrap) begin
                o_sec <= o_sec + 6'd1;
            end else begin
                o_sec <= '0;
                if (!min_wrap) begin
                    o_min <= o_min + 6'd1;
                end else begin
                    o_min  <= '0;
                    o_hour <= hour_wrap ? 5'd0 : o_hour + 5'd1;
                end
            end
        end else if (set_inc) begin
            case (o_sel)
                2'd0:    o_sec  <= sec_wrap  ? 6'd0 : o_sec  + 6'd1;
                2'd1:    o_min  <= min_wrap  ? 6'd0 : o_min  + 6'd1;
                2'd2:    o_hour <= hour_wrap ? 5'd0 : o_hour + 5'd1;
                default: ;
            endcase
        end
    end

`ifdef CLK_BLINK_EN
    // ------------------------------------------------------------------
    // Blink counter. It toggles o_blank every max(num/2,1) cycles while
    // in SET. It is held cleared in RUN, so each SET entry starts from
    // phase 0.
    // ------------------------------------------------------------------
    logic [31:0] bcnt;
    logic [31:0] half;
    logic        blink_hit;

    assign half      = (num[31:1] == 31'd0) ? 32'd1 : {1'b0, num[31:1]};
    assign blink_hit = ({1'b0, bcnt} + 33'd1) >= {1'b0, half};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt    <= '0;
            o_blank <= 1'b0;
        end else if (blink_en) begin
            if (blink_hit) begin
                bcnt    <= '0;
                o_blank <= ~o_blank;
            end else begin
                bcnt    <= bcnt + 32'd1;
            end
        end else begin
            bcnt    <= '0;
            o_blank <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_ctrl
//   Directed self-checking bench for clock_ctrl. It covers reset state, the
//   prescaler period, SET editing and wrap, pulse priority, the cascade and
//   full rollover, async reset in SET, a mid-count change of num, and (with
//   CLK_BLINK_EN) the blink phase.
// -----------------------------------------------------------------------------
module tb_clock_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] num;
    logic        i_mode, i_pos, i_inc;
    logic [5:0]  o_sec, o_min;
    logic [4:0]  o_hour;
    logic        o_mode, o_tick;
    logic [1:0]  o_sel;
`ifdef CLK_BLINK_EN
    logic        o_blank;
`endif

    int checks   = 0;
    int failures = 0;

    clock_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .num    (num),
        .i_mode (i_mode),
        .i_pos  (i_pos),
        .i_inc  (i_inc),
        .o_sec  (o_sec),
        .o_min  (o_min),
        .o_hour (o_hour),
        .o_mode (o_mode),
        .o_sel  (o_sel),
        .o_tick (o_tick)
`ifdef CLK_BLINK_EN
        ,
        .o_blank(o_blank)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n active edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic m, input logic p, input logic i);
        i_mode = m; i_pos = p; i_inc = i;
        step(1);
        i_mode = 1'b0; i_pos = 1'b0; i_inc = 1'b0;
    endtask

    task automatic inc_n(input int n);
        repeat (n) pulse(1'b0, 1'b0, 1'b1);
    endtask

    // Reset pulse inside a clock low/high phase, clear of any edge.
    task automatic hard_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; num = 32'd4;
        i_mode = 1'b0; i_pos = 1'b0; i_inc = 1'b0;
        step(1);

        // Reset state
        chk("rst_sec",  32'(o_sec),  0);
        chk("rst_min",  32'(o_min),  0);
        chk("rst_hour", 32'(o_hour), 0);
        chk("rst_mode", 32'(o_mode), 0);
        chk("rst_sel",  32'(o_sel),  0);
        chk("rst_tick", 32'(o_tick), 0);
        rst_n = 1'b1;

        // num=4: first tick on the 4th edge after release, then every 4
        step(3);
        chk("pre_tick3", 32'(o_tick), 0);
        step(1);
        chk("tick4",     32'(o_tick), 1);
        chk("tick4_sec", 32'(o_sec),  1);
        step(1);
        chk("tick5",     32'(o_tick), 0);
        step(3);
        chk("tick8",     32'(o_tick), 1);
        chk("tick8_sec", 32'(o_sec),  2);

        // SET editing from a clean state
        hard_reset();
        pulse(1'b1, 1'b0, 1'b0);
        chk("set_mode", 32'(o_mode), 1);
        chk("set_sel",  32'(o_sel),  0);
        chk("set_tick", 32'(o_tick), 0);
        inc_n(3);
        chk("inc3_sec", 32'(o_sec), 3);
        chk("inc3_min", 32'(o_min), 0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("pos_sel1", 32'(o_sel), 1);
        inc_n(59);
        chk("min59", 32'(o_min), 59);
        inc_n(1);
        chk("min_wrap",      32'(o_min),  0);
        chk("min_wrap_hour", 32'(o_hour), 0);
        chk("min_wrap_sec",  32'(o_sec),  3);
        pulse(1'b0, 1'b1, 1'b0);
        chk("pos_sel2", 32'(o_sel), 2);
        pulse(1'b0, 1'b1, 1'b0);
        chk("pos_sel0", 32'(o_sel), 0);

        // pos+inc together: increment the old field, then advance
        pulse(1'b0, 1'b1, 1'b1);
        chk("posinc_sec", 32'(o_sec), 4);
        chk("posinc_sel", 32'(o_sel), 1);

        // mode+inc together: mode wins, min untouched
        pulse(1'b1, 1'b0, 1'b1);
        chk("prio_mode", 32'(o_mode), 0);
        chk("prio_min",  32'(o_min),  0);
        chk("prio_sec",  32'(o_sec),  4);

        // Back in RUN: first tick num=4 edges after the return edge
        step(3);
        chk("ret_tick3", 32'(o_tick), 0);
        step(1);
        chk("ret_tick4", 32'(o_tick), 1);
        chk("ret_sec",   32'(o_sec),  5);

        // i_inc in RUN is ignored
        pulse(1'b0, 1'b0, 1'b1);
        chk("run_inc_sec",  32'(o_sec),  5);
        chk("run_inc_min",  32'(o_min),  0);
        chk("run_inc_mode", 32'(o_mode), 0);

        // Cascade: preload 00:59:58 with num=1
        num = 32'd1;
        hard_reset();
        pulse(1'b1, 1'b0, 1'b0);
        inc_n(58);
        pulse(1'b0, 1'b1, 1'b0);
        inc_n(59);
        pulse(1'b1, 1'b0, 1'b0);
        step(1);
        chk("casc1_tick", 32'(o_tick), 1);
        chk("casc1_sec",  32'(o_sec),  59);
        chk("casc1_min",  32'(o_min),  59);
        step(1);
        chk("casc2_sec",  32'(o_sec),  0);
        chk("casc2_min",  32'(o_min),  0);
        chk("casc2_hour", 32'(o_hour), 1);

        // Full rollover from 23:59:59
        hard_reset();
        pulse(1'b1, 1'b0, 1'b0);
        inc_n(59);
        pulse(1'b0, 1'b1, 1'b0);
        inc_n(59);
        pulse(1'b0, 1'b1, 1'b0);
        inc_n(23);
        chk("pre_roll_hour", 32'(o_hour), 23);
        pulse(1'b1, 1'b0, 1'b0);
        step(1);
        chk("roll_tick", 32'(o_tick), 1);
        chk("roll_sec",  32'(o_sec),  0);
        chk("roll_min",  32'(o_min),  0);
        chk("roll_hour", 32'(o_hour), 0);

        // num=0 ticks every cycle
        num = 32'd0;
        step(1);
        chk("num0_tick", 32'(o_tick), 1);
        chk("num0_sec",  32'(o_sec),  1);

        // Async reset in SET with hour selected
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        inc_n(1);
        chk("set2_sel",  32'(o_sel),  2);
        chk("set2_hour", 32'(o_hour), 1);
        rst_n = 1'b0;
        #2;
        chk("arst_mode", 32'(o_mode), 0);
        chk("arst_sel",  32'(o_sel),  0);
        chk("arst_hour", 32'(o_hour), 0);
        chk("arst_sec",  32'(o_sec),  0);
        rst_n = 1'b1;

        // num shrinks from 100 to 2 while cnt=50: tick on the next edge
        num = 32'd100;
        hard_reset();
        step(50);
        chk("n100_tick", 32'(o_tick), 0);
        num = 32'd2;
        step(1);
        chk("shrink_tick", 32'(o_tick), 1);
        chk("shrink_sec",  32'(o_sec),  1);

`ifdef CLK_BLINK_EN
        // Blink: num=8 toggles every 4 cycles in SET, cleared in RUN
        num = 32'd8;
        hard_reset();
        pulse(1'b1, 1'b0, 1'b0);
        chk("blink_entry", 32'(o_blank), 0);
        step(3);
        chk("blink_e3", 32'(o_blank), 0);
        step(1);
        chk("blink_e4", 32'(o_blank), 1);
        step(3);
        chk("blink_e7", 32'(o_blank), 1);
        step(1);
        chk("blink_e8", 32'(o_blank), 0);
        step(4);
        chk("blink_e12", 32'(o_blank), 1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("blink_run", 32'(o_blank), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
